// File: rtl/lif_neuron_core.sv
// Leaky integrate-and-fire neuron: integrates one synaptic current sample per
// handshake, fires a registered spike on threshold, then sits out a refractory window.
module lif_neuron_core #(
    parameter int WIDTH          = 16,
    parameter int DECIMAL_BITS   = 8,
    parameter int THRESHOLD      = 1 << DECIMAL_BITS,
    parameter int V_RESET        = 0,
    parameter int LEAK_SHIFT     = 4,
    parameter int REFRAC_SAMPLES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_syn,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             valid_out,
    input  logic             ready_in,
    output logic             spike_out,
    output logic [WIDTH-1:0] membrane,
    output logic             refractory,
    output logic [7:0]       spike_count
);

    localparam int CNT_W = (REFRAC_SAMPLES > 0) ? $clog2(REFRAC_SAMPLES + 1) : 1;
    localparam logic [WIDTH-1:0] THRESH_W  = WIDTH'(THRESHOLD);
    localparam logic [WIDTH-1:0] V_RESET_W = WIDTH'(V_RESET);
    localparam logic [CNT_W-1:0] REFRAC_W  = CNT_W'(REFRAC_SAMPLES);

    typedef enum logic {
        ST_INTEG,
        ST_REFRAC
    } state_t;

    state_t           r_state, w_stateNext;
    logic [WIDTH-1:0] r_v, w_vNext;
    logic [CNT_W-1:0] r_refracCnt, w_refracCntNext;

    logic             r_validOut, w_validOutNext;
    logic             r_spike, w_spikeNext;
    logic [WIDTH-1:0] r_membrane, w_membraneNext;
    logic             r_refrac, w_refracNext;
    logic [7:0]       r_spikeCount, w_spikeCountNext;

    logic             w_accept;
    logic [WIDTH-1:0] w_leak;
    logic [WIDTH:0]   w_sumWide;
    logic [WIDTH-1:0] w_sum;

    assign ready_out = ready_in | ~r_validOut;
    assign w_accept  = valid_in & ready_out;

    // Leak and integrate with one extra bit so an overflow clamps to full scale instead of wrapping.
    assign w_leak    = r_v - (r_v >> LEAK_SHIFT);
    assign w_sumWide = {1'b0, w_leak} + {1'b0, i_syn};
    assign w_sum     = w_sumWide[WIDTH] ? {WIDTH{1'b1}} : w_sumWide[WIDTH-1:0];

    always_comb begin
        w_stateNext      = r_state;
        w_vNext          = r_v;
        w_refracCntNext  = r_refracCnt;
        w_validOutNext   = w_accept | (r_validOut & ~ready_in);
        w_spikeNext      = r_spike;
        w_membraneNext   = r_membrane;
        w_refracNext     = r_refrac;
        w_spikeCountNext = r_spikeCount;

        if (w_accept) begin
            unique case (r_state)
                ST_INTEG: begin
                    w_refracNext = 1'b0;
                    if (w_sum >= THRESH_W) begin
                        w_vNext        = V_RESET_W;
                        w_spikeNext    = 1'b1;
                        w_membraneNext = V_RESET_W;
                        if (r_spikeCount != 8'hFF) begin
                            w_spikeCountNext = r_spikeCount + 8'd1;
                        end
                        if (REFRAC_SAMPLES > 0) begin
                            w_stateNext     = ST_REFRAC;
                            w_refracCntNext = REFRAC_W;
                        end
                    end else begin
                        w_vNext        = w_sum;
                        w_spikeNext    = 1'b0;
                        w_membraneNext = w_sum;
                    end
                end
                ST_REFRAC: begin
                    // Refractory samples are consumed but neither integrated nor leaked.
                    w_spikeNext     = 1'b0;
                    w_refracNext    = 1'b1;
                    w_membraneNext  = r_v;
                    w_refracCntNext = r_refracCnt - CNT_W'(1);
                    if (r_refracCnt <= CNT_W'(1)) begin
                        w_stateNext     = ST_INTEG;
                        w_refracCntNext = '0;
                    end
                end
                default: begin
                    w_stateNext = ST_INTEG;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_INTEG;
            r_v          <= '0;
            r_refracCnt  <= '0;
            r_validOut   <= 1'b0;
            r_spike      <= 1'b0;
            r_membrane   <= '0;
            r_refrac     <= 1'b0;
            r_spikeCount <= 8'd0;
        end else begin
            r_state      <= w_stateNext;
            r_v          <= w_vNext;
            r_refracCnt  <= w_refracCntNext;
            r_validOut   <= w_validOutNext;
            r_spike      <= w_spikeNext;
            r_membrane   <= w_membraneNext;
            r_refrac     <= w_refracNext;
            r_spikeCount <= w_spikeCountNext;
        end
    end

    assign valid_out   = r_validOut;
    assign spike_out   = r_spike;
    assign membrane    = r_membrane;
    assign refractory  = r_refrac;
    assign spike_count = r_spikeCount;

endmodule
